// File: rtl/uart_dt_tx_if.sv
// Message handshake and serial-line bundle for the duty-cycle UART
// transmitter. The controller side drives START/ASCII and observes the
// transmitter status; the transmitter side does the opposite.
interface uart_dt_tx_if;
    logic        START;
    logic [23:0] ASCII;
    logic        TX;
    logic        BUSY;
    logic        DONE;

    modport master (
        output START,
        output ASCII,
        input  TX,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  START,
        input  ASCII,
        output TX,
        output BUSY,
        output DONE
    );
endinterface

// File: rtl/uart_dt_tx.sv
// 8N1 UART transmitter for a 3-character duty-cycle readout followed by CR LF.
// Optional suppression of leading '0' characters in the hundreds/tens slots.
// Characters are sent back to back with no gap; DONE pulses once per message.
module uart_dt_tx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter bit SUPPRESS_LZ  = 1'b1
) (
    input  logic          CLK,
    input  logic          RESET,
    uart_dt_tx_if.slave   bus
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [7:0] CHAR_ZERO = 8'h30;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [2:0] IDX_LF    = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT,
        NEXT_CHAR
    } state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [2:0]        idx;
    logic [7:0]        hund;
    logic [7:0]        tens;
    logic [7:0]        units;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic              baud_last;
    logic [2:0]        next_bit;
    logic [2:0]        first_idx;
    logic [7:0]        cur_char;

    assign accept    = (state == IDLE) && bus.START;
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign next_bit  = bit_cnt + 3'd1;

    // Index of the first character to send, with leading-zero skipping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        first_idx = 3'd0;
        if (SUPPRESS_LZ && (bus.ASCII[23:16] == CHAR_ZERO)) begin
            first_idx = (bus.ASCII[15:8] == CHAR_ZERO) ? 3'd2 : 3'd1;
        end
    end

    // Character currently being serialised: three digits, then CR, then LF.
    always_comb begin
        cur_char = CHAR_LF;
        case (idx)
            3'd0:    cur_char = hund;
            3'd1:    cur_char = tens;
            3'd2:    cur_char = units;
            3'd3:    cur_char = CHAR_CR;
            default: cur_char = CHAR_LF;
        endcase
    end

    // Message capture at acceptance; later ASCII changes cannot disturb a message in flight.
    always_ff @(posedge CLK) begin
        // NOTE: message storage is deliberately not reset; it is always rewritten before it is read.
        if (accept) begin
            hund  <= bus.ASCII[23:16];
            tens  <= bus.ASCII[15:8];
            units <= bus.ASCII[7:0];
        end
    end

    // Transmit FSM with registered TX/BUSY/DONE and baud/bit/char counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            idx      <= 3'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                    baud_cnt <= '0;
                    bit_cnt  <= 3'd0;
                    if (bus.START) begin
                        idx    <= first_idx;
                        state  <= START_BIT;
                        tx_q   <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end

                START_BIT: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= 3'd0;
                        tx_q     <= cur_char[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= next_bit;
                        if (bit_cnt == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP_BIT;
                        end else begin
                            tx_q <= cur_char[next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP_BIT: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (idx == IDX_LF) begin
                            state  <= IDLE;
                            tx_q   <= 1'b1;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            // Next-character bookkeeping folded into the final stop cycle.
                            idx   <= idx + 3'd1;
                            tx_q  <= 1'b0;
                            state <= START_BIT;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                NEXT_CHAR: begin
                    // Not entered in normal operation; recovers by starting the next character.
                    baud_cnt <= '0;
                    idx      <= idx + 3'd1;
                    tx_q     <= 1'b0;
                    state    <= START_BIT;
                end

                default: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TX   = tx_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule
